div_seq: RTL

- Multi-cycle iterative divider with its own sequencer, sitting beside the EX stage.
- EX launches a DIV/DIVU through a start/ready handshake. The block raises a stall request so the pipeline holds EX until the quotient and remainder are ready.
- Results go back to EX and are written to HI/LO.
- Replaces any single-cycle divide path in the ALU with one subtract/shift step per cycle.

---
 rtl/div_seq_if.sv | 34 +++
 rtl/div_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
//   master : EX side, drives the operands, start and annul, observes results.
//   slave  : divider side.
// Signals:
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held by EX until ready_o is seen
//   annul_i       flush of the in-flight divide
//   result_o      {remainder, quotient}, valid while ready_o = 1
//   ready_o       result valid
//   stallreq_o    combinational pipeline stall request
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider beside the EX stage. One subtract/shift step per
// cycle; DATA_W steps per divide, plus a one-cycle fast path for a zero divisor.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   div_if  slave side of div_seq_if (operands, start/annul, result/ready/stall)
module div_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  div_if
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;      // holds the dividend, quotient bits shift in
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                dvd_neg_q, dvd_neg_d;
  logic                dvs_neg_q, dvs_neg_d;
  logic                signed_q, signed_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W:0]     rem_sh, trial;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; only signed operands with the MSB set are negated.
  always_comb begin
    op1_mag = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1]) ?
              (~div_if.opdata1_i + DATA_W'(1)) : div_if.opdata1_i;
    op2_mag = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1]) ?
              (~div_if.opdata2_i + DATA_W'(1)) : div_if.opdata2_i;
  end

  // One restoring step. rem < divisor, so the shifted remainder fits DATA_W+1
  // bits and the trial MSB is its sign.
  always_comb begin
    rem_sh   = {rem_q, quo_q[DATA_W-1]};
    trial    = rem_sh - {1'b0, divisor_q};
    rem_step = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_step = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    quo_fix  = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (~quo_step + DATA_W'(1)) : quo_step;
    rem_fix  = (signed_q && dvd_neg_q) ? (~rem_step + DATA_W'(1)) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    signed_d  = signed_q;
    result_d  = result_q;

    unique case (state_q)
      StFree: begin
        if (div_if.start_i && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d   = StOn;
            rem_d     = '0;
            quo_d     = op1_mag;
            divisor_d = op2_mag;
            dvd_neg_d = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
            dvs_neg_d = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
            signed_d  = div_if.signed_div_i;
            cnt_d     = '0;
          end
        end
      end
      StByZero: begin
        result_d = '0;
        state_d  = StEnd;
      end
      StOn: begin
        if (div_if.annul_i) begin
          state_d = StFree;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            result_d = {rem_fix, quo_fix};
            state_d  = StEnd;
          end
        end
      end
      StEnd: begin
        if (!div_if.start_i || div_if.annul_i) begin
          state_d  = StFree;
          result_d = '0;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
    end
  end

  assign div_if.result_o   = result_q;
  assign div_if.ready_o    = (state_q == StEnd);
  // Drops in the END cycle so EX consumes the result while ready_o is high.
  assign div_if.stallreq_o = ~rst & div_if.start_i & ~div_if.annul_i & (state_q != StEnd);

endmodule
